// File: rtl/flight_cmd_pkg.sv
// Shared definitions for the flight command/config block.
//   - opcode values decoded from the UART wrapper
//   - response bytes returned on resp
//   - the command FSM state type
package flight_cmd_pkg;

   localparam logic [7:0] OP_PTCH     = 8'h02;
   localparam logic [7:0] OP_ROLL     = 8'h03;
   localparam logic [7:0] OP_YAW      = 8'h04;
   localparam logic [7:0] OP_THRST    = 8'h05;
   localparam logic [7:0] OP_CAL      = 8'h06;
   localparam logic [7:0] OP_EMER     = 8'h07;
   localparam logic [7:0] OP_MTRS_OFF = 8'h08;

   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_NACK = 8'hEE;

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      CAL,
      LAND
   } cmd_state_t;

endpackage

// File: rtl/cmd_tick_timer.sv
// Clearable free-running up-counter with an all-ones flag.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear (dominates counting)
//   full        high while the count is all ones
module cmd_tick_timer #(
   parameter int W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic full
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else          cnt <= cnt + W'(1);
   end

   assign full = &cnt;

endmodule

// File: rtl/flight_cmd_cfg.sv
// Command/config FSM between the UART wrapper and the flight controller.
// Decodes opcodes, holds attitude/thrust setpoints, sequences motor spin-up
// calibration, NACKs unknown opcodes, lands on link loss and ramps thrust
// down during landing.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cmd_rdy/cmd/data  command from the UART wrapper
//   cal_done          inertial calibration finished
//   clr_cmd_rdy       command consumed (combinational)
//   send_resp/resp    registered one-cycle response strobe and byte
//   d_ptch/d_roll/d_yaw/thrst  setpoints
//   strt_cal          one-cycle calibration start pulse
//   inertial_cal      high in RAMP or CAL
//   motors_off        ESC kill
//   landing           high in LAND
//
// state | meaning
// IDLE  | accept commands; watchdog runs when motors are on
// RAMP  | motors spinning up, ramp timer counting to all-ones
// CAL   | inertial calibration running, waiting for cal_done
// LAND  | attitude zeroed, thrust stepped down once per landing tick
module flight_cmd_cfg
   import flight_cmd_pkg::*;
#(
   parameter int FAST_SIM  = 1,
   parameter int DATA_W    = 16,
   parameter int THRST_W   = 9,
   parameter int RAMP_W    = 9,
   parameter int WDOG_W    = 10,
   parameter int LAND_DIV  = 4,
   parameter int LAND_STEP = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_rdy,
   input  logic [7:0]         cmd,
   input  logic [DATA_W-1:0]  data,
   input  logic               cal_done,
   output logic               clr_cmd_rdy,
   output logic               send_resp,
   output logic [7:0]         resp,
   output logic [DATA_W-1:0]  d_ptch,
   output logic [DATA_W-1:0]  d_roll,
   output logic [DATA_W-1:0]  d_yaw,
   output logic [THRST_W-1:0] thrst,
   output logic               strt_cal,
   output logic               inertial_cal,
   output logic               motors_off,
   output logic               landing
);

   localparam int RAMP_BITS = (FAST_SIM != 0) ? RAMP_W   : 26;
   localparam int WDOG_BITS = (FAST_SIM != 0) ? WDOG_W   : 27;
   localparam int LAND_BITS = (FAST_SIM != 0) ? LAND_DIV : 20;
   localparam logic [THRST_W-1:0] STEP = THRST_W'(LAND_STEP);

   cmd_state_t state, state_nxt;
   logic       ramp_full, wdog_full, land_tick, wdog_run;
   logic       wr_ptch, wr_roll, wr_yaw, wr_thrst, zero_att, thrst_dec;
   logic       set_mtrs, clr_mtrs, resp_vld, go_cal;
   logic [7:0] resp_val;

   assign wdog_run     = (state == IDLE) && !motors_off;
   assign inertial_cal = (state == RAMP) || (state == CAL);
   assign landing      = (state == LAND);

   // Timers are held clear outside their own state, so each starts at 0 on entry.
   cmd_tick_timer #(.W(RAMP_BITS)) u_ramp_tmr (
      .clk(clk), .rst_n(rst_n), .clr(state != RAMP), .full(ramp_full));

   cmd_tick_timer #(.W(WDOG_BITS)) u_wdog_tmr (
      .clk(clk), .rst_n(rst_n), .clr(!wdog_run || clr_cmd_rdy), .full(wdog_full));

   cmd_tick_timer #(.W(LAND_BITS)) u_land_pre (
      .clk(clk), .rst_n(rst_n), .clr(state != LAND), .full(land_tick));

   always_comb begin
      state_nxt   = state;
      clr_cmd_rdy = 1'b0;
      wr_ptch     = 1'b0;
      wr_roll     = 1'b0;
      wr_yaw      = 1'b0;
      wr_thrst    = 1'b0;
      zero_att    = 1'b0;
      thrst_dec   = 1'b0;
      set_mtrs    = 1'b0;
      clr_mtrs    = 1'b0;
      resp_vld    = 1'b0;
      resp_val    = RESP_ACK;
      go_cal      = 1'b0;
      case (state)
         IDLE: begin
            // A pending command beats a simultaneous watchdog expiry.
            if (cmd_rdy) begin
               clr_cmd_rdy = 1'b1;
               case (cmd)
                  OP_PTCH:     begin wr_ptch  = 1'b1; resp_vld = 1'b1; end
                  OP_ROLL:     begin wr_roll  = 1'b1; resp_vld = 1'b1; end
                  OP_YAW:      begin wr_yaw   = 1'b1; resp_vld = 1'b1; end
                  OP_THRST:    begin wr_thrst = 1'b1; resp_vld = 1'b1; end
                  OP_CAL:      begin clr_mtrs = 1'b1; state_nxt = RAMP; end
                  OP_EMER:     begin zero_att = 1'b1; resp_vld = 1'b1; state_nxt = LAND; end
                  OP_MTRS_OFF: begin set_mtrs = 1'b1; resp_vld = 1'b1; end
                  default:     begin resp_vld = 1'b1; resp_val = RESP_NACK; end
               endcase
            end else if (wdog_run && wdog_full) begin
               zero_att  = 1'b1;
               state_nxt = LAND;
            end
         end
         RAMP: begin
            if (ramp_full) begin
               go_cal    = 1'b1;
               state_nxt = CAL;
            end
         end
         CAL: begin
            if (cal_done) begin
               resp_vld  = 1'b1;
               state_nxt = IDLE;
            end
         end
         LAND: begin
            if (cmd_rdy) begin
               clr_cmd_rdy = 1'b1;
               resp_vld    = 1'b1;
               if (cmd == OP_MTRS_OFF) begin
                  set_mtrs  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  resp_val = RESP_NACK;
               end
            end
            // A NACKed command does not cost a landing tick.
            if (land_tick && !(cmd_rdy && cmd == OP_MTRS_OFF)) begin
               if (thrst == '0) begin
                  set_mtrs  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  thrst_dec = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         d_ptch     <= '0;
         d_roll     <= '0;
         d_yaw      <= '0;
         thrst      <= '0;
         motors_off <= 1'b1;
         send_resp  <= 1'b0;
         resp       <= 8'h00;
         strt_cal   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (zero_att) begin
            d_ptch <= '0;
            d_roll <= '0;
            d_yaw  <= '0;
         end else begin
            if (wr_ptch) d_ptch <= data;
            if (wr_roll) d_roll <= data;
            if (wr_yaw)  d_yaw  <= data;
         end
         if (wr_thrst)       thrst <= data[THRST_W-1:0];
         else if (thrst_dec) thrst <= (thrst > STEP) ? thrst - STEP : '0;
         if (set_mtrs)      motors_off <= 1'b1;
         else if (clr_mtrs) motors_off <= 1'b0;
         send_resp <= resp_vld;
         if (resp_vld) resp <= resp_val;
         strt_cal <= go_cal;
      end
   end

endmodule

// File: tb/tb_flight_cmd_cfg.sv
// Directed bench for flight_cmd_cfg with default (FAST_SIM) parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_flight_cmd_cfg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_rdy = 1'b0;
   logic [7:0]  cmd = 8'h00;
   logic [15:0] data = 16'h0000;
   logic        cal_done = 1'b0;
   logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, landing;
   logic [7:0]  resp;
   logic [15:0] d_ptch, d_roll, d_yaw;
   logic [8:0]  thrst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   flight_cmd_cfg dut (
      .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
      .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
      .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
      .thrst(thrst), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
      .motors_off(motors_off), .landing(landing));

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Calibrate from IDLE; returns the RAMP length in cycles, or -1 on timeout.
   task automatic spin_up(output int n);
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
      step();
      cmd_rdy = 1'b0;
      n = 0;
      while (!strt_cal && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) n = -1;
      cal_done = 1'b1;
      step();
      cal_done = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (d_ptch !== 16'h0 || d_roll !== 16'h0 || d_yaw !== 16'h0 || thrst !== 9'h0) begin
         errors++;
         $display("FAIL reset_setpoints: got %h %h %h %h want all 0", d_ptch, d_roll, d_yaw, thrst);
      end
      checks++;
      if ({motors_off, send_resp, strt_cal, inertial_cal, landing, clr_cmd_rdy} !== 6'b100000 || resp !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got mo=%b sr=%b sc=%b ic=%b ld=%b clr=%b resp=%h want mo=1 others 0 resp=00",
                  motors_off, send_resp, strt_cal, inertial_cal, landing, clr_cmd_rdy, resp);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_ptch_write();
      cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h1234;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b1 || send_resp !== 1'b0 || d_ptch !== 16'h0) begin
         errors++;
         $display("FAIL ptch_same_cycle: clr=%b sr=%b ptch=%h want clr=1 sr=0 ptch=0000", clr_cmd_rdy, send_resp, d_ptch);
      end
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (d_ptch !== 16'h1234 || send_resp !== 1'b1 || resp !== 8'hA5) begin
         errors++;
         $display("FAIL ptch_write: ptch=%h sr=%b resp=%h want 1234 1 A5", d_ptch, send_resp, resp);
      end
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b0) begin
         errors++;
         $display("FAIL ptch_clr_drop: clr=%b want 0", clr_cmd_rdy);
      end
      step();
      checks++;
      if (send_resp !== 1'b0) begin
         errors++;
         $display("FAIL ptch_resp_width: sr=%b want 0", send_resp);
      end
   endtask

   task automatic test_nack();
      cmd_rdy = 1'b1; cmd = 8'h0F; data = 16'hFFFF;
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (send_resp !== 1'b1 || resp !== 8'hEE) begin
         errors++;
         $display("FAIL nack_resp: sr=%b resp=%h want 1 EE", send_resp, resp);
      end
      checks++;
      if (d_ptch !== 16'h1234 || d_roll !== 16'h0 || d_yaw !== 16'h0 || thrst !== 9'h0 || motors_off !== 1'b1 || inertial_cal !== 1'b0) begin
         errors++;
         $display("FAIL nack_no_change: %h %h %h %h mo=%b ic=%b want 1234 0 0 0 mo=1 ic=0",
                  d_ptch, d_roll, d_yaw, thrst, motors_off, inertial_cal);
      end
      step();
      checks++;
      if (send_resp !== 1'b0) begin
         errors++;
         $display("FAIL nack_resp_width: sr=%b want 0", send_resp);
      end
   endtask

   task automatic test_cal();
      int n;
      bit resp_seen;
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL cal_consume: clr=%b want 1", clr_cmd_rdy);
      end
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (inertial_cal !== 1'b1 || motors_off !== 1'b0 || send_resp !== 1'b0) begin
         errors++;
         $display("FAIL cal_enter: ic=%b mo=%b sr=%b want 1 0 0", inertial_cal, motors_off, send_resp);
      end
      n = 0;
      resp_seen = 1'b0;
      while (!strt_cal && n < 2000) begin
         step();
         n++;
         if (send_resp) resp_seen = 1'b1;
      end
      // Timer shows 0..511 across 512 RAMP cycles; the registered pulse follows.
      checks++;
      if (n !== 512 || resp_seen) begin
         errors++;
         $display("FAIL cal_ramp_len: strt_cal after %0d cycles resp_seen=%b want 512 0", n, resp_seen);
      end
      step();
      checks++;
      if (strt_cal !== 1'b0 || inertial_cal !== 1'b1) begin
         errors++;
         $display("FAIL cal_pulse: sc=%b ic=%b want 0 1", strt_cal, inertial_cal);
      end
      cmd_rdy = 1'b1; cmd = 8'h04; data = 16'h0055;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b0) begin
         errors++;
         $display("FAIL cal_pending: clr=%b want 0", clr_cmd_rdy);
      end
      step();
      step();
      cal_done = 1'b1;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b0 || d_yaw !== 16'h0) begin
         errors++;
         $display("FAIL cal_hold_cmd: clr=%b yaw=%h want 0 0000", clr_cmd_rdy, d_yaw);
      end
      step();
      cal_done = 1'b0;
      checks++;
      if (send_resp !== 1'b1 || resp !== 8'hA5 || inertial_cal !== 1'b0 || d_yaw !== 16'h0) begin
         errors++;
         $display("FAIL cal_ack: sr=%b resp=%h ic=%b yaw=%h want 1 A5 0 0000", send_resp, resp, inertial_cal, d_yaw);
      end
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL cal_pending_taken: clr=%b want 1", clr_cmd_rdy);
      end
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (d_yaw !== 16'h0055 || send_resp !== 1'b1 || resp !== 8'hA5 || motors_off !== 1'b0) begin
         errors++;
         $display("FAIL cal_then_yaw: yaw=%h sr=%b resp=%h mo=%b want 0055 1 A5 0", d_yaw, send_resp, resp, motors_off);
      end
   endtask

   task automatic test_land();
      logic [8:0] exp;
      bit bad;
      cmd_rdy = 1'b1; cmd = 8'h05; data = 16'h00F0;
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (thrst !== 9'h0F0 || send_resp !== 1'b1 || resp !== 8'hA5) begin
         errors++;
         $display("FAIL thrst_write: thrst=%h sr=%b resp=%h want 0F0 1 A5", thrst, send_resp, resp);
      end
      cmd_rdy = 1'b1; cmd = 8'h07;
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (landing !== 1'b1 || send_resp !== 1'b1 || resp !== 8'hA5 || d_ptch !== 16'h0 || d_yaw !== 16'h0 || thrst !== 9'h0F0) begin
         errors++;
         $display("FAIL land_enter: ld=%b sr=%b resp=%h ptch=%h yaw=%h thrst=%h want 1 1 A5 0 0 0F0",
                  landing, send_resp, resp, d_ptch, d_yaw, thrst);
      end
      bad = 1'b0;
      for (int k = 1; k < 496; k++) begin
         step();
         exp = ((k / 16) * 8 >= 240) ? 9'h0 : 9'(240 - (k / 16) * 8);
         if (!bad && (thrst !== exp || landing !== 1'b1 || send_resp !== 1'b0)) begin
            bad = 1'b1;
            $display("FAIL land_ramp k=%0d: thrst=%h ld=%b sr=%b want %h 1 0", k, thrst, landing, send_resp, exp);
         end
      end
      checks++;
      if (bad) errors++;
      step();
      checks++;
      if (landing !== 1'b0 || motors_off !== 1'b1 || thrst !== 9'h0) begin
         errors++;
         $display("FAIL land_done: ld=%b mo=%b thrst=%h want 0 1 000", landing, motors_off, thrst);
      end
   endtask

   task automatic test_wdog_expiry();
      int n;
      bit bad;
      spin_up(n);
      checks++;
      if (n !== 512 || motors_off !== 1'b0) begin
         errors++;
         $display("FAIL wdog_spinup: ramp=%0d mo=%b want 512 0", n, motors_off);
      end
      cmd_rdy = 1'b1; cmd = 8'h05; data = 16'h000C;
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (thrst !== 9'h00C || resp !== 8'hA5) begin
         errors++;
         $display("FAIL wdog_thrst: thrst=%h resp=%h want 00C A5", thrst, resp);
      end
      bad = 1'b0;
      for (int j = 2; j <= 1024; j++) begin
         step();
         if (!bad && (landing !== 1'b0 || send_resp !== 1'b0)) begin
            bad = 1'b1;
            $display("FAIL wdog_early j=%0d: ld=%b sr=%b want 0 0", j, landing, send_resp);
         end
      end
      checks++;
      if (bad) errors++;
      step();
      checks++;
      if (landing !== 1'b1 || send_resp !== 1'b0) begin
         errors++;
         $display("FAIL wdog_expire: ld=%b sr=%b want 1 0", landing, send_resp);
      end
      for (int k = 0; k < 16; k++) step();
      checks++;
      if (thrst !== 9'h004) begin
         errors++;
         $display("FAIL wdog_land_step: thrst=%h want 004", thrst);
      end
   endtask

   // Continues in the LAND state entered by the watchdog (LAND cycle 16).
   task automatic test_land_cmds();
      for (int k = 0; k < 4; k++) step();
      cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h7777;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL land_consume: clr=%b want 1", clr_cmd_rdy);
      end
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (send_resp !== 1'b1 || resp !== 8'hEE || d_roll !== 16'h0 || landing !== 1'b1) begin
         errors++;
         $display("FAIL land_nack: sr=%b resp=%h roll=%h ld=%b want 1 EE 0000 1", send_resp, resp, d_roll, landing);
      end
      for (int k = 0; k < 11; k++) step();
      checks++;
      if (thrst !== 9'h000 || landing !== 1'b1) begin
         errors++;
         $display("FAIL land_saturate: thrst=%h ld=%b want 000 1", thrst, landing);
      end
      for (int k = 0; k < 4; k++) step();
      cmd_rdy = 1'b1; cmd = 8'h08; data = 16'h0000;
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (send_resp !== 1'b1 || resp !== 8'hA5 || motors_off !== 1'b1 || landing !== 1'b0) begin
         errors++;
         $display("FAIL land_mtrs_off: sr=%b resp=%h mo=%b ld=%b want 1 A5 1 0", send_resp, resp, motors_off, landing);
      end
   endtask

   task automatic test_cmd_beats_wdog();
      int n;
      spin_up(n);
      checks++;
      if (n !== 512) begin
         errors++;
         $display("FAIL race_spinup: ramp=%0d want 512", n);
      end
      cmd_rdy = 1'b1; cmd = 8'h05; data = 16'h0020;
      step();
      cmd_rdy = 1'b0;
      for (int j = 2; j <= 1024; j++) step();
      cmd_rdy = 1'b1; cmd = 8'h05; data = 16'h0030;
      #1;
      checks++;
      if (clr_cmd_rdy !== 1'b1 || landing !== 1'b0) begin
         errors++;
         $display("FAIL race_consume: clr=%b ld=%b want 1 0", clr_cmd_rdy, landing);
      end
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (landing !== 1'b0 || send_resp !== 1'b1 || resp !== 8'hA5 || thrst !== 9'h030) begin
         errors++;
         $display("FAIL race_cmd_wins: ld=%b sr=%b resp=%h thrst=%h want 0 1 A5 030", landing, send_resp, resp, thrst);
      end
      for (int k = 0; k < 3; k++) step();
      checks++;
      if (landing !== 1'b0) begin
         errors++;
         $display("FAIL race_no_land: ld=%b want 0", landing);
      end
      cmd_rdy = 1'b1; cmd = 8'h08;
      step();
      cmd_rdy = 1'b0;
      checks++;
      if (motors_off !== 1'b1 || send_resp !== 1'b1 || resp !== 8'hA5 || thrst !== 9'h030 || d_yaw !== 16'h0) begin
         errors++;
         $display("FAIL idle_mtrs_off: mo=%b sr=%b resp=%h thrst=%h yaw=%h want 1 1 A5 030 0000",
                  motors_off, send_resp, resp, thrst, d_yaw);
      end
   endtask

   task automatic test_reset_mid_ramp();
      bit bad;
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
      step();
      cmd_rdy = 1'b0;
      for (int k = 0; k < 100; k++) step();
      checks++;
      if (inertial_cal !== 1'b1 || motors_off !== 1'b0) begin
         errors++;
         $display("FAIL rst_ramp_pre: ic=%b mo=%b want 1 0", inertial_cal, motors_off);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (inertial_cal !== 1'b0 || motors_off !== 1'b1 || thrst !== 9'h0 || resp !== 8'h00 ||
          send_resp !== 1'b0 || strt_cal !== 1'b0 || landing !== 1'b0) begin
         errors++;
         $display("FAIL rst_ramp_abort: ic=%b mo=%b thrst=%h resp=%h sr=%b sc=%b ld=%b want 0 1 000 00 0 0 0",
                  inertial_cal, motors_off, thrst, resp, send_resp, strt_cal, landing);
      end
      step();
      step();
      rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 600; k++) begin
         step();
         if (!bad && (strt_cal !== 1'b0 || send_resp !== 1'b0 || inertial_cal !== 1'b0)) begin
            bad = 1'b1;
            $display("FAIL rst_ramp_quiet k=%0d: sc=%b sr=%b ic=%b want 0 0 0", k, strt_cal, send_resp, inertial_cal);
         end
      end
      checks++;
      if (bad) errors++;
   endtask

   initial begin
      test_reset();
      test_ptch_write();
      test_nack();
      test_cal();
      test_land();
      test_wdog_expiry();
      test_land_cmds();
      test_cmd_beats_wdog();
      test_reset_mid_ramp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete within 500000 time units");
      $fatal(1, "timeout");
   end

endmodule
